fp_mul_pack: RTL and testbench

- Output stage of the FP32 multiply path. It consumes the 24-bit mantissa multiplier's outputs (mant_normalize, mant_frac, mant_ready) together with operand signs, exponents and special-value class flags.
- It computes the result sign and biased exponent, resolves special cases, detects overflow/underflow, and packs an IEEE-754 single-precision word.
- Each result is held behind a valid/ack handshake for the downstream consumer.
- A watchdog flags a mantissa multiplier that never asserts ready.

---
 rtl/fp_mul_pack.sv | 185 ++++++++++++++++++
 tb/tb_fp_mul_pack.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pack.sv
// fp_mul_pack -- output stage of the FP32 multiply path.
//
// Takes operand signs, biased exponents and class flags with a one-cycle
// start request. Special cases (NaN, inf, zero) resolve immediately. Normal
// operands wait for the mantissa multiplier, then the biased exponent is
// formed, checked for overflow/underflow and packed with the fraction.
// Results are held behind a valid/ack handshake. A watchdog forces a qNaN
// timeout result if the mantissa multiplier never reports ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     one-cycle request, sampled only in IDLE
//   sign_a/b, exp_a/b         operand signs and biased exponents
//   a/b_zero, a/b_inf, a/b_nan operand class flags, valid with start
//   mant_ready                mantissa product valid (level)
//   mant_normalize            product MSB was bit 47, exponent +1
//   mant_frac                 rounded 23-bit fraction
//   out_ack                   consumer accepts the held result
//   busy                      high in WAIT and DONE
//   out_valid                 result valid, held until acked
//   result                    packed FP32 word
//   overflow/underflow/invalid/timeout  status, valid with out_valid
module fp_mul_pack #(
    parameter int BIAS           = 127,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMO_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic        a_zero,
    input  logic        b_zero,
    input  logic        a_inf,
    input  logic        b_inf,
    input  logic        a_nan,
    input  logic        b_nan,
    input  logic        mant_ready,
    input  logic        mant_normalize,
    input  logic [22:0] mant_frac,
    input  logic        out_ack,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid,
    output logic        timeout
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic        ovf;
        logic        unf;
    } norm_t;

    state_t            state_q;
    logic              sign_q;
    logic [7:0]        exp_a_q;
    logic [7:0]        exp_b_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_d;

    logic              sign_in;
    logic              spec_hit;
    logic              spec_inv;
    logic [31:0]       spec_word;
    norm_t             norm_r;

    // Exponent sum is formed 10-bit signed so that neither the +BIAS overshoot
    // (up to 384) nor the negative underflow range (down to -127) wraps.
    function automatic norm_t pack_normal(input logic        s,
                                          input logic [7:0]  ea,
                                          input logic [7:0]  eb,
                                          input logic        norm,
                                          input logic [22:0] frac);
        norm_t             r;
        logic signed [9:0] e;
        e = $signed({2'b00, ea}) + $signed({2'b00, eb})
            - $signed(10'(BIAS)) + $signed({9'd0, norm});
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (e >= 10'sd255) begin
            r.word = {s, 8'hFF, 23'h0};
            r.ovf  = 1'b1;
        end else if (e <= 10'sd0) begin
            // Flush-to-zero: no subnormal results are produced.
            r.word = {s, 31'h0};
            r.unf  = 1'b1;
        end else begin
            r.word = {s, e[7:0], frac};
        end
        return r;
    endfunction

    always_comb begin
        sign_in  = sign_a ^ sign_b;
        spec_hit = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
        spec_inv = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        if (spec_inv) begin
            spec_word = QNAN;
        end else if (a_inf | b_inf) begin
            spec_word = {sign_in, 8'hFF, 23'h0};
        end else begin
            spec_word = {sign_in, 31'h0};
        end
        tmo_d  = tmo_q + TMO_W'(1);
        norm_r = pack_normal(sign_q, exp_a_q, exp_b_q, mant_normalize, mant_frac);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            exp_a_q   <= 8'h0;
            exp_b_q   <= 8'h0;
            tmo_q     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result    <= 32'h0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= sign_in;
                        exp_a_q <= exp_a;
                        exp_b_q <= exp_b;
                        busy    <= 1'b1;
                        if (spec_hit) begin
                            result    <= spec_word;
                            invalid   <= spec_inv;
                            out_valid <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            tmo_q   <= '0;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A product arriving on the watchdog's last cycle still wins.
                    if (mant_ready) begin
                        result    <= norm_r.word;
                        overflow  <= norm_r.ovf;
                        underflow <= norm_r.unf;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
                        tmo_q     <= tmo_d;
                        result    <= QNAN;
                        timeout   <= 1'b1;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                DONE: begin
                    if (out_ack) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        invalid   <= 1'b0;
                        timeout   <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_pack.sv
module tb_fp_mul_pack;

    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sign_a = 1'b0, sign_b = 1'b0;
    logic [7:0]  exp_a = 8'h0, exp_b = 8'h0;
    logic        a_zero = 1'b0, b_zero = 1'b0, a_inf = 1'b0, b_inf = 1'b0;
    logic        a_nan = 1'b0, b_nan = 1'b0;
    logic        mant_ready = 1'b0, mant_normalize = 1'b0;
    logic [22:0] mant_frac = 23'h0;
    logic        out_ack = 1'b0;
    logic        busy, out_valid, overflow, underflow, invalid, timeout;
    logic [31:0] result;

    int pass_cnt = 0;
    int total_cnt = 0;

    fp_mul_pack #(.BIAS(127), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMO_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
        .a_zero(a_zero), .b_zero(b_zero), .a_inf(a_inf), .b_inf(b_inf),
        .a_nan(a_nan), .b_nan(b_nan),
        .mant_ready(mant_ready), .mant_normalize(mant_normalize), .mant_frac(mant_frac),
        .out_ack(out_ack), .busy(busy), .out_valid(out_valid), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached: bench did not finish");
        $fatal(1);
    end

    // Reference model: flags vector is {overflow, underflow, invalid, timeout}.
    function automatic void model(input bit sa, input bit sb, input int ea, input int eb,
                                  input bit az, input bit bz, input bit ai, input bit bi,
                                  input bit an, input bit bn, input bit norm, input int frac,
                                  output logic [31:0] w, output logic [3:0] f);
        bit s;
        int e;
        s = sa ^ sb;
        f = 4'b0000;
        if (an || bn || (ai && bz) || (bi && az)) begin
            w = 32'h7FC00000;
            f = 4'b0010;
        end else if (ai || bi) begin
            w = (32'(s) << 31) | 32'h7F800000;
        end else if (az || bz) begin
            w = 32'(s) << 31;
        end else begin
            e = ea + eb - 127 + int'(norm);
            if (e >= 255) begin
                w = (32'(s) << 31) | 32'h7F800000;
                f = 4'b1000;
            end else if (e <= 0) begin
                w = 32'(s) << 31;
                f = 4'b0100;
            end else begin
                w = (32'(s) << 31) | (32'(e) << 23) | 32'(frac);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_start(input bit sa, input bit sb, input int ea, input int eb,
                               input bit az, input bit bz, input bit ai, input bit bi,
                               input bit an, input bit bn);
        sign_a = sa; sign_b = sb; exp_a = 8'(ea); exp_b = 8'(eb);
        a_zero = az; b_zero = bz; a_inf = ai; b_inf = bi; a_nan = an; b_nan = bn;
        start = 1'b1;
        step();
        start = 1'b0;
        a_zero = 0; b_zero = 0; a_inf = 0; b_inf = 0; a_nan = 0; b_nan = 0;
    endtask

    task automatic give_ready(input bit norm, input int frac);
        mant_ready = 1'b1; mant_normalize = norm; mant_frac = 23'(frac);
        step();
        mant_ready = 1'b0; mant_normalize = 1'b0;
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        total_cnt++;
        if ({busy, out_valid} !== 2'b00) $display("FAIL reset_ctrl busy/valid=%b want 00", {busy, out_valid});
        else pass_cnt++;
        total_cnt++;
        if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result);
        else pass_cnt++;
        total_cnt++;
        if ({overflow, underflow, invalid, timeout} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000", {overflow, underflow, invalid, timeout});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [31:0] w; logic [3:0] f;
        model(0, 0, 127, 128, 0, 0, 0, 0, 0, 0, 0, 32'h400000, w, f);
        apply_start(0, 0, 127, 128, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if ({busy, out_valid} !== 2'b10) $display("FAIL basic_wait busy/valid=%b want 10", {busy, out_valid});
        else pass_cnt++;
        step();
        give_ready(0, 32'h400000);
        total_cnt++;
        if (out_valid !== 1'b1 || result !== w) $display("FAIL basic_result valid=%b result=%h want 1 %h", out_valid, result, w);
        else pass_cnt++;
        total_cnt++;
        if ({overflow, underflow, invalid, timeout} !== f) $display("FAIL basic_flags got %b want %b", {overflow, underflow, invalid, timeout}, f);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || result !== 32'h40400000)
                $display("FAIL basic_hold%0d valid=%b result=%h want 1 40400000", i, out_valid, result);
            else pass_cnt++;
        end
        do_ack();
        total_cnt++;
        if ({busy, out_valid} !== 2'b00) $display("FAIL basic_ack busy/valid=%b want 00", {busy, out_valid});
        else pass_cnt++;
    endtask

    // Normal-path table: overflow/underflow and the exponent boundaries around them.
    task automatic test_normal_table();
        int ea[7]   = '{200, 191, 190, 10, 63, 63, 128};
        int eb[7]   = '{200, 191, 191, 10, 64, 64, 1};
        bit nm[7]   = '{1,   0,   0,   0,  0,  1,  0};
        bit sa[7]   = '{0,   1,   0,   1,  0,  1,  1};
        logic [31:0] w; logic [3:0] f;
        for (int i = 0; i < 7; i++) begin
            model(sa[i], 0, ea[i], eb[i], 0, 0, 0, 0, 0, 0, nm[i], 32'h12345, w, f);
            apply_start(sa[i], 0, ea[i], eb[i], 0, 0, 0, 0, 0, 0);
            give_ready(nm[i], 32'h12345);
            total_cnt++;
            if (out_valid !== 1'b1 || result !== w || {overflow, underflow, invalid, timeout} !== f)
                $display("FAIL normal_case%0d valid=%b result=%h flags=%b want 1 %h %b",
                         i, out_valid, result, {overflow, underflow, invalid, timeout}, w, f);
            else pass_cnt++;
            do_ack();
        end
    endtask

    task automatic test_special();
        apply_start(0, 0, 130, 0, 0, 1, 1, 0, 0, 0);
        total_cnt++;
        if (out_valid !== 1'b1 || result !== 32'h7FC00000 || invalid !== 1'b1)
            $display("FAIL special_inf_zero valid=%b result=%h invalid=%b want 1 7fc00000 1", out_valid, result, invalid);
        else pass_cnt++;
        do_ack();
        apply_start(0, 1, 0, 130, 1, 0, 0, 0, 0, 0);
        total_cnt++;
        if (out_valid !== 1'b1 || result !== 32'h80000000 || {overflow, underflow, invalid, timeout} !== 4'b0)
            $display("FAIL special_zero valid=%b result=%h flags=%b want 1 80000000 0000",
                     out_valid, result, {overflow, underflow, invalid, timeout});
        else pass_cnt++;
        do_ack();
    endtask

    task automatic test_timeout();
        int n;
        apply_start(0, 0, 127, 127, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            start = (n == 4);
            // The stray start carries special flags; it must not alter anything.
            a_nan = (n == 4);
            step();
            start = 1'b0; a_nan = 1'b0;
            n++;
        end
        total_cnt++;
        if (n !== TIMEOUT_CYCLES) $display("FAIL timeout_latency got %0d cycles want %0d", n, TIMEOUT_CYCLES);
        else pass_cnt++;
        total_cnt++;
        if (result !== 32'h7FC00000 || {overflow, underflow, invalid, timeout} !== 4'b0001)
            $display("FAIL timeout_result result=%h flags=%b want 7fc00000 0001",
                     result, {overflow, underflow, invalid, timeout});
        else pass_cnt++;
        // Start coincident with ack must not launch a new operation.
        start = 1'b1;
        do_ack();
        start = 1'b0;
        total_cnt++;
        if ({busy, out_valid, timeout} !== 3'b000)
            $display("FAIL ack_with_start busy/valid/timeout=%b want 000", {busy, out_valid, timeout});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] w; logic [3:0] f;
        bit seen;
        apply_start(1, 1, 130, 125, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        give_ready(0, 32'h1);
        total_cnt++;
        if ({busy, out_valid} !== 2'b00) $display("FAIL rst_mid busy/valid=%b want 00", {busy, out_valid});
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid === 1'b1) seen = 1;
        end
        total_cnt++;
        if (seen) $display("FAIL rst_mid_no_valid out_valid rose=1 want 0");
        else pass_cnt++;
        model(1, 0, 130, 125, 0, 0, 0, 0, 0, 0, 1, 32'h2AAAAA, w, f);
        apply_start(1, 0, 130, 125, 0, 0, 0, 0, 0, 0);
        give_ready(1, 32'h2AAAAA);
        total_cnt++;
        if (out_valid !== 1'b1 || result !== w || {overflow, underflow, invalid, timeout} !== f)
            $display("FAIL rst_mid_after valid=%b result=%h want 1 %h", out_valid, result, w);
        else pass_cnt++;
        do_ack();
    endtask

    task automatic test_random();
        logic [31:0] w; logic [3:0] f;
        bit sa, sb, az, bz, ai, bi, an, bn, nm, special;
        int ea, eb, fr, dly, ackd;
        for (int it = 0; it < 60; it++) begin
            sa = 1'($urandom); sb = 1'($urandom);
            ea = int'($urandom_range(0, 255)); eb = int'($urandom_range(0, 255));
            nm = 1'($urandom); fr = int'($urandom_range(0, 32'h7FFFFF));
            az = 0; bz = 0; ai = 0; bi = 0; an = 0; bn = 0;
            if ($urandom_range(0, 9) > 6) begin
                az = ($urandom_range(0, 2) == 0); bz = ($urandom_range(0, 2) == 0);
                ai = ($urandom_range(0, 2) == 0) && !az; bi = ($urandom_range(0, 2) == 0) && !bz;
                an = ($urandom_range(0, 4) == 0); bn = ($urandom_range(0, 4) == 0);
            end
            special = az | bz | ai | bi | an | bn;
            model(sa, sb, ea, eb, az, bz, ai, bi, an, bn, nm, fr, w, f);
            apply_start(sa, sb, ea, eb, az, bz, ai, bi, an, bn);
            if (!special) begin
                dly = int'($urandom_range(0, 6));
                for (int d = 0; d < dly; d++) step();
                total_cnt++;
                if (out_valid !== 1'b0) $display("FAIL rand%0d_early valid=%b want 0", it, out_valid);
                else pass_cnt++;
                give_ready(nm, fr);
            end
            total_cnt++;
            if (out_valid !== 1'b1 || result !== w || {overflow, underflow, invalid, timeout} !== f)
                $display("FAIL rand%0d valid=%b result=%h flags=%b want 1 %h %b",
                         it, out_valid, result, {overflow, underflow, invalid, timeout}, w, f);
            else pass_cnt++;
            ackd = int'($urandom_range(0, 2));
            for (int d = 0; d < ackd; d++) step();
            do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_normal_table();
        test_special();
        test_timeout();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
